// File: rtl/lin_seq_ctrl_pkg.sv
// ============================================================================
// Module      : lin_seq_ctrl_pkg
// Description : Shared constants, derived widths, FSM state and MAC slot types
//               for the bit-serial linear unit sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package lin_seq_ctrl_pkg;

  localparam int LIN_SIZE         = 84;   // parallel output neurons per tile
  localparam int LIN_CHANNELS_MAX = 120;  // max input/output channels per layer
  localparam int ACT_BITS         = 3;    // activation bit planes
  localparam int LIN_MEM_LAT      = 2;    // default read latency (1..4)

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  localparam int LIN_TILES_MAX = (LIN_CHANNELS_MAX + LIN_SIZE - 1) / LIN_SIZE;
  localparam int CH_W  = $clog2(LIN_CHANNELS_MAX + 1);
  localparam int WA_W  = $clog2(LIN_TILES_MAX * LIN_CHANNELS_MAX);
  localparam int AA_W  = $clog2(LIN_CHANNELS_MAX);
  localparam int AB_W  = max1($clog2(ACT_BITS));
  localparam int TL_W  = max1($clog2(LIN_TILES_MAX));

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    ACCUM  = 3'd2,
    SHIFT  = 3'd3,
    DRAIN  = 3'd4,
    OUTPUT = 3'd5
  } lin_seq_state_t;

  // One issue slot worth of MAC strobes; at most one bit is set.
  typedef struct packed {
    logic clear;
    logic en;
    logic shift;
  } lin_slot_t;

endpackage

`default_nettype wire

// File: rtl/lin_seq_ctrl_if.sv
// ============================================================================
// Module      : lin_seq_ctrl_if
// Description : Memory-read, MAC-strobe and tile-writeback bundle between the
//               sequencer (master) and the datapath/writeback stage (slave).
//               Signals: wgt_rd_en/wgt_addr, act_rd_en/act_addr/act_bit,
//               mac_clear/mac_en/mac_shift, out_valid/out_ready/out_tile.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lin_seq_ctrl_if;
  import lin_seq_ctrl_pkg::*;

  logic            wgt_rd_en;
  logic [WA_W-1:0] wgt_addr;
  logic            act_rd_en;
  logic [AA_W-1:0] act_addr;
  logic [AB_W-1:0] act_bit;
  logic            mac_clear;
  logic            mac_en;
  logic            mac_shift;
  logic            out_valid;
  logic            out_ready;
  logic [TL_W-1:0] out_tile;

  modport master (
    output wgt_rd_en, wgt_addr, act_rd_en, act_addr, act_bit,
    output mac_clear, mac_en, mac_shift,
    output out_valid, out_tile,
    input  out_ready
  );

  modport slave (
    input  wgt_rd_en, wgt_addr, act_rd_en, act_addr, act_bit,
    input  mac_clear, mac_en, mac_shift,
    input  out_valid, out_tile,
    output out_ready
  );

endinterface

`default_nettype wire

// File: rtl/lin_seq_ctrl_delay.sv
// ============================================================================
// Module      : lin_seq_delay
// Description : DEPTH-stage shift register of MAC issue slots, so that the
//               clear/en/shift strobes line up with read data arriving at the
//               MAC. Synchronous reset flushes every stage.
//   Ports: clk, rst, slot_in (issue-stage slot), slot_out (delayed slot)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lin_seq_delay
  import lin_seq_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  lin_slot_t slot_in,
  output lin_slot_t slot_out
);

  lin_slot_t [DEPTH-1:0] r_pipe;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= slot_in;
      for (int i = 1; i < DEPTH; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign slot_out = r_pipe[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/lin_seq_ctrl.sv
// ============================================================================
// Module      : lin_seq_ctrl
// Description : Run sequencer for the bit-serial linear unit. Walks output
//               tiles, activation bit planes (MSB first) and input channels,
//               issuing memory reads and latency-aligned MAC strobes, then
//               hands each finished tile to writeback via valid/ready.
//   Ports: clk, rst, start, in_channels, out_channels, busy, done, cfg_err,
//          bus (lin_seq_ctrl_if.master), and with LIN_SEQ_PERF_EN defined
//          perf_cycles / perf_stall.
//   Optional macro: LIN_SEQ_PERF_EN adds busy-cycle and output-stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lin_seq_ctrl
  import lin_seq_ctrl_pkg::*;
#(
  parameter int MEM_LAT = LIN_MEM_LAT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CH_W-1:0] in_channels,
  input  logic [CH_W-1:0] out_channels,
  output logic            busy,
  output logic            done,
  output logic            cfg_err,
`ifdef LIN_SEQ_PERF_EN
  output logic [31:0]     perf_cycles,
  output logic [31:0]     perf_stall,
`endif
  lin_seq_ctrl_if.master  bus
);

  // Output channels covered once the current tile finishes: (tile+1)*LIN_SIZE.
  localparam int COV_W = $clog2(LIN_TILES_MAX * LIN_SIZE + 1);

  lin_seq_state_t   r_state, w_state_n;
  logic [CH_W-1:0]  r_in_ch, r_out_ch;
  logic [COV_W-1:0] r_cov;
  logic [AA_W-1:0]  r_ic;
  logic [AB_W-1:0]  r_bit;
  logic [TL_W-1:0]  r_tile;
  logic [WA_W-1:0]  r_base;
  logic [2:0]       r_drain;
  logic             w_cfg_ok, w_ic_last, w_last_tile, w_drain_end, w_rd;
  lin_slot_t        w_slot, w_mac;

  assign w_cfg_ok = (in_channels  != '0) && (in_channels  <= CH_W'(LIN_CHANNELS_MAX)) &&
                    (out_channels != '0) && (out_channels <= CH_W'(LIN_CHANNELS_MAX));
  assign w_ic_last   = (CH_W'(r_ic) == r_in_ch - 1'b1);
  assign w_last_tile = (r_cov >= COV_W'(r_out_ch));
  assign w_drain_end = (r_drain == 3'(MEM_LAT - 1));

  always_comb begin
    w_state_n = r_state;
    w_slot    = '0;
    case (r_state)
      IDLE:   if (start && w_cfg_ok) w_state_n = CLEAR;
      CLEAR: begin
        w_slot.clear = 1'b1;
        w_state_n    = ACCUM;
      end
      ACCUM: begin
        w_slot.en = 1'b1;
        if (w_ic_last) w_state_n = (r_bit == '0) ? DRAIN : SHIFT;
      end
      SHIFT: begin
        w_slot.shift = 1'b1;
        w_state_n    = ACCUM;
      end
      DRAIN:  if (w_drain_end) w_state_n = OUTPUT;
      OUTPUT: if (bus.out_ready) w_state_n = w_last_tile ? IDLE : CLEAR;
      default: w_state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_in_ch  <= '0;
      r_out_ch <= '0;
      r_cov    <= '0;
      r_ic     <= '0;
      r_bit    <= '0;
      r_tile   <= '0;
      r_base   <= '0;
      r_drain  <= '0;
      done     <= 1'b0;
      cfg_err  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      done    <= 1'b0;
      cfg_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            if (w_cfg_ok) begin
              r_in_ch  <= in_channels;
              r_out_ch <= out_channels;
              r_cov    <= COV_W'(LIN_SIZE);
              r_tile   <= '0;
              r_base   <= '0;
            end else begin
              cfg_err <= 1'b1;
            end
          end
        end
        CLEAR: begin
          r_ic  <= '0;
          r_bit <= AB_W'(ACT_BITS - 1);
        end
        ACCUM: r_ic <= w_ic_last ? '0 : r_ic + 1'b1;
        SHIFT: begin
          r_ic  <= '0;
          r_bit <= r_bit - 1'b1;
        end
        DRAIN: r_drain <= w_drain_end ? 3'd0 : r_drain + 3'd1;
        OUTPUT: begin
          if (bus.out_ready) begin
            if (w_last_tile) begin
              done <= 1'b1;
            end else begin
              // Next tile's weight rows start in_channels further on.
              r_tile <= r_tile + 1'b1;
              r_base <= r_base + WA_W'(r_in_ch);
              r_cov  <= r_cov + COV_W'(LIN_SIZE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  lin_seq_delay #(.DEPTH(MEM_LAT)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .slot_in  (w_slot),
    .slot_out (w_mac)
  );

  assign w_rd          = (r_state == ACCUM);
  assign busy          = (r_state != IDLE);
  assign bus.wgt_rd_en = w_rd;
  assign bus.act_rd_en = w_rd;
  assign bus.wgt_addr  = w_rd ? r_base + WA_W'(r_ic) : '0;
  assign bus.act_addr  = w_rd ? r_ic : '0;
  assign bus.act_bit   = w_rd ? r_bit : '0;
  assign bus.mac_clear = w_mac.clear;
  assign bus.mac_en    = w_mac.en;
  assign bus.mac_shift = w_mac.shift;
  assign bus.out_valid = (r_state == OUTPUT);
  assign bus.out_tile  = r_tile;

`ifdef LIN_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else if (r_state == IDLE && start && w_cfg_ok) begin
      perf_cycles <= '0;
      perf_stall  <= '0;
    end else begin
      if (r_state != IDLE) perf_cycles <= perf_cycles + 32'd1;
      if (r_state == OUTPUT && !bus.out_ready) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_lin_seq_ctrl.sv
// ============================================================================
// Module      : tb_lin_seq_ctrl
// Description : Self-checking bench for lin_seq_ctrl. A run-level model builds
//               each tile's expected issue schedule as a list of rows and is
//               compared with the DUT every cycle; directed tests add literal
//               expectations for read counts, latencies and addresses.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_lin_seq_ctrl;
  import lin_seq_ctrl_pkg::*;

  localparam int MLAT = 2;

  logic            clk = 1'b0;
  logic            rst, start;
  logic [CH_W-1:0] in_channels, out_channels;
  logic            busy, done, cfg_err;
`ifdef LIN_SEQ_PERF_EN
  logic [31:0]     perf_cycles, perf_stall;
`endif

  lin_seq_ctrl_if bus ();

  lin_seq_ctrl #(.MEM_LAT(MLAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_channels  (in_channels),
    .out_channels (out_channels),
    .busy         (busy),
    .done         (done),
    .cfg_err      (cfg_err),
`ifdef LIN_SEQ_PERF_EN
    .perf_cycles  (perf_cycles),
    .perf_stall   (perf_stall),
`endif
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- run-level model ----------------
  typedef struct {
    bit rd; int wa; int aa; int ab; bit cl; bit en; bit sh;
  } row_t;

  row_t     prog[$];   // remaining issue rows of the current tile (incl. drain)
  bit [2:0] mpipe[$];  // {clear,en,shift} issued MLAT cycles ago at the front
  bit       m_busy, m_done, m_err;
  int       m_tile, m_nt, m_in;

  // monitor tallies (zeroed by the driver between tests)
  int n_reads, n_shifts;
  int first_addr[$];
  int bit_seq[$];

  function automatic void model_reset();
    m_busy = 0; m_done = 0; m_err = 0; m_tile = 0;
    prog.delete();
    mpipe.delete();
    for (int i = 0; i < MLAT; i++) mpipe.push_back(3'b000);
  endfunction

  function automatic void load_tile(input int t);
    row_t r;
    r = '{default: 0}; r.cl = 1; prog.push_back(r);
    for (int b = ACT_BITS - 1; b >= 0; b--) begin
      for (int ic = 0; ic < m_in; ic++) begin
        r = '{default: 0};
        r.rd = 1; r.en = 1; r.wa = t * m_in + ic; r.aa = ic; r.ab = b;
        prog.push_back(r);
      end
      if (b > 0) begin
        r = '{default: 0}; r.sh = 1; prog.push_back(r);
      end
    end
    for (int i = 0; i < MLAT; i++) begin
      r = '{default: 0}; prog.push_back(r);
    end
  endfunction

  always @(negedge clk) begin
    row_t cur;
    bit   outp;
    cur  = '{default: 0};
    outp = m_busy && (prog.size() == 0);
    if (m_busy && prog.size() > 0) cur = prog[0];

    check("busy", busy, m_busy);
    check("done", done, m_done);
    check("cfg_err", cfg_err, m_err);
    check("wgt_rd_en", bus.wgt_rd_en, cur.rd);
    check("act_rd_en", bus.act_rd_en, cur.rd);
    if (cur.rd) begin
      check("wgt_addr", bus.wgt_addr, cur.wa);
      check("act_addr", bus.act_addr, cur.aa);
      check("act_bit", bus.act_bit, cur.ab);
    end
    check("mac_clear", bus.mac_clear, mpipe[0][2]);
    check("mac_en", bus.mac_en, mpipe[0][1]);
    check("mac_shift", bus.mac_shift, mpipe[0][0]);
    check("out_valid", bus.out_valid, outp);
    if (outp) check("out_tile", bus.out_tile, m_tile);

    if (bus.wgt_rd_en === 1'b1) n_reads++;
    if (bus.mac_shift === 1'b1) n_shifts++;
    if (bus.wgt_rd_en === 1'b1 && bus.act_addr == 0 && bus.act_bit == ACT_BITS - 1)
      first_addr.push_back(int'(bus.wgt_addr));
    if (bus.wgt_rd_en === 1'b1 && (bit_seq.size() == 0 || bit_seq[$] != int'(bus.act_bit)))
      bit_seq.push_back(int'(bus.act_bit));

    // advance the model by the inputs the DUT samples at the next edge
    if (rst) begin
      model_reset();
    end else begin
      mpipe.push_back({cur.cl, cur.en, cur.sh});
      void'(mpipe.pop_front());
      m_done = 0;
      m_err  = 0;
      if (!m_busy) begin
        if (start) begin
          if (in_channels >= 1 && in_channels <= LIN_CHANNELS_MAX &&
              out_channels >= 1 && out_channels <= LIN_CHANNELS_MAX) begin
            m_busy = 1;
            m_in   = int'(in_channels);
            m_nt   = (int'(out_channels) + LIN_SIZE - 1) / LIN_SIZE;
            m_tile = 0;
            load_tile(0);
          end else begin
            m_err = 1;
          end
        end
      end else if (prog.size() > 0) begin
        void'(prog.pop_front());
      end else if (bus.out_ready) begin
        if (m_tile == m_nt - 1) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_tile++;
          load_tile(m_tile);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input int i, input int o);
    in_channels  = CH_W'(i);
    out_channels = CH_W'(o);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clr_tally();
    n_reads = 0; n_shifts = 0;
    first_addr.delete();
    bit_seq.delete();
  endtask

  // cycles from the CLEAR cycle until out_valid shows
  task automatic cycles_to_valid(output int n);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 2000) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      tick();
      n++;
    end
    check(name, done, 1'b1);
  endtask

  initial begin
    int n;
    model_reset();
    rst = 1'b1; start = 1'b0; in_channels = '0; out_channels = '0;
    bus.out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // reset state
    check("rst_busy", busy, 1'b0);
    check("rst_rd", bus.wgt_rd_en, 1'b0);
    check("rst_valid", bus.out_valid, 1'b0);
    check("rst_clear", bus.mac_clear, 1'b0);

    // single tile, 84 x 84
    clr_tally();
    pulse_start(84, 84);
    cycles_to_valid(n);
    check("t1_lat", n, 257);
    tick();
    check("t1_done", done, 1'b1);
    check("t1_busy_drop", busy, 1'b0);
    check("t1_reads", n_reads, 252);
    check("t1_shifts", n_shifts, 2);
    check("t1_bitseq_len", bit_seq.size(), 3);
    check("t1_bit0", bit_seq.size() > 0 ? bit_seq[0] : -1, 2);
    check("t1_bit2", bit_seq.size() > 2 ? bit_seq[2] : -1, 0);
    tick();

    // two tiles with a 5-cycle writeback stall on tile 0
    clr_tally();
    bus.out_ready = 1'b0;
    pulse_start(84, 120);
    cycles_to_valid(n);
    check("t2_lat", n, 257);
    check("t2_tile0", bus.out_tile, 0);
    repeat (5) tick();
    check("t2_hold_valid", bus.out_valid, 1'b1);
    check("t2_hold_tile", bus.out_tile, 0);
    bus.out_ready = 1'b1;
    wait_done("t2_done");
    check("t2_tile1_base", first_addr.size() > 1 ? first_addr[1] : -1, 84);
    check("t2_reads", n_reads, 504);
`ifdef LIN_SEQ_PERF_EN
    check("t2_perf_stall", perf_stall, 5);
    check("t2_perf_cycles", perf_cycles, 521);
`endif
    tick();

    // minimum layer
    clr_tally();
    pulse_start(1, 1);
    cycles_to_valid(n);
    check("t3_lat", n, 8);
    wait_done("t3_done");
    check("t3_reads", n_reads, 3);
    check("t3_shifts", n_shifts, 2);
    tick();

    // bad configurations
    clr_tally();
    pulse_start(0, 10);
    check("t4_err_in0", cfg_err, 1'b1);
    check("t4_busy_in0", busy, 1'b0);
    tick();
    pulse_start(10, 121);
    check("t4_err_out121", cfg_err, 1'b1);
    tick();
    check("t4_reads", n_reads, 0);

    // reset in the middle of tile 0
    pulse_start(84, 84);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_busy", busy, 1'b0);
    check("t5_rd", bus.wgt_rd_en, 1'b0);
    check("t5_valid", bus.out_valid, 1'b0);
    check("t5_done", done, 1'b0);
    repeat (4) tick();
    clr_tally();
    pulse_start(2, 10);
    cycles_to_valid(n);
    check("t5_lat", n, 11);
    wait_done("t5_rerun_done");
    check("t5_reads", n_reads, 6);
    tick();

    // start while busy with a different config is ignored
    clr_tally();
    pulse_start(4, 100);
    repeat (3) tick();
    pulse_start(1, 1);
    wait_done("t6_done");
    check("t6_reads", n_reads, 24);
    check("t6_tile1_base", first_addr.size() > 1 ? first_addr[1] : -1, 4);
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/lin_seq_ctrl.md
Name: lin_seq_ctrl

Overview:
- Sequencer for the bit-serial linear unit. The unit has LIN_SIZE parallel output neurons.
- Per run, walks output tiles, activation bit planes (MSB first) and input channels.
- Issues weight/activation memory reads and MAC clear/enable/shift strobes, aligned to memory latency.
- Hands each finished tile to the writeback stage via valid/ready.

Parameters:
- LIN_SIZE, 84, parallel output neurons per tile
- LIN_CHANNELS_MAX, 120, max input or output channels per layer
- ACT_BITS, 3, activation bit planes
- MEM_LAT, 2, read latency (cycles) from rd_en to data at the MAC; range 1..4

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle run request
- in_channels  in  CH_W  layer input channels; CH_W = $clog2(LIN_CHANNELS_MAX+1)
- out_channels  in  CH_W  layer output channels
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after the last tile is accepted
- cfg_err  out  1  one-cycle pulse when start is rejected for bad config
- wgt_rd_en  out  1  weight row read strobe
- wgt_addr  out  WA_W  weight row = tile*in_channels + ic
- act_rd_en  out  1  activation read strobe
- act_addr  out  AA_W  input channel index ic
- act_bit  out  AB_W  bit-plane index, travels with act_addr
- mac_clear  out  1  zero accumulators (delayed MEM_LAT)
- mac_en  out  1  accumulate current data (delayed MEM_LAT)
- mac_shift  out  1  accumulator <<= 1 (delayed MEM_LAT)
- out_valid  out  1  tile result available
- out_ready  in  1  writeback accepts the tile
- out_tile  out  TL_W  tile index of the presented result

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0; delay pipeline flushed. Applies from any state, so a mid-run reset abandons the run with no done pulse.
- start in IDLE:
  - Config is valid iff 1 <= in_channels <= LIN_CHANNELS_MAX and 1 <= out_channels <= LIN_CHANNELS_MAX.
  - Invalid config: cfg_err pulses the next cycle and state stays IDLE.
  - Valid config: configuration is latched, busy = 1 the next cycle, state goes to CLEAR.
  - start while busy is ignored. Latched config is immune to later input changes.
- Tiles: NT = ceil(out_channels/LIN_SIZE); tile runs 0..NT-1.
- Issue-stage states and transitions:
  - CLEAR (1 cycle): issues a clear slot -> ACCUM, bit = ACT_BITS-1, ic = 0.
  - ACCUM (1 cycle per ic): wgt_rd_en = act_rd_en = 1, with addresses as above.
    - ic = in_channels-1 and bit > 0 -> SHIFT.
    - ic = in_channels-1 and bit = 0 -> DRAIN.
  - SHIFT (1 cycle): no reads; issues a shift slot; bit--, ic = 0 -> ACCUM.
  - DRAIN: waits MEM_LAT cycles until the pipeline is empty -> OUTPUT.
  - OUTPUT: out_valid = 1 and out_tile is held stable until out_ready.
    - On handshake, last tile: done pulses, busy drops, -> IDLE.
    - On handshake, otherwise: tile++ -> CLEAR.
    - out_valid deasserts the cycle after handshake.
    - out_ready is ignored outside OUTPUT.
- Delay pipeline: mac_clear/mac_en/mac_shift are their issue-slot flags delayed exactly MEM_LAT cycles. Read strobes and addresses are not delayed. At most one of the three MAC strobes is high per cycle.
- Cycles per tile, issue to out_valid: 1 + ACT_BITS*in_channels + (ACT_BITS-1) + MEM_LAT.
- Width rules:
  - WA_W = $clog2(ceil(MAX/LIN_SIZE)*MAX)
  - AA_W = $clog2(MAX)
  - AB_W = max(1, $clog2(ACT_BITS))
  - TL_W = max(1, $clog2(ceil(MAX/LIN_SIZE)))
  - wgt_addr is computed incrementally (row base += in_channels per tile); no multiplier.
- in_channels = 1: every ACCUM lasts one cycle and SHIFT follows directly. This is legal.

Optional Feature:
- Macro LIN_SEQ_PERF_EN.
- Defined: adds outputs perf_cycles (32 bit) and perf_stall (32 bit).
  - Both clear on an accepted start.
  - perf_cycles counts busy cycles; perf_stall counts OUTPUT cycles with out_ready = 0.
  - Both hold after done; reset clears them.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- pkg_linear gains:
  - derived constants CH_W, WA_W, AA_W, AB_W, TL_W and LIN_TILES_MAX = ceil(LIN_CHANNELS_MAX/LIN_SIZE);
  - enum lin_seq_state_t {IDLE, CLEAR, ACCUM, SHIFT, DRAIN, OUTPUT};
  - struct lin_slot_t {clear, en, shift}.
- Natural sub-module: lin_seq_delay, a MEM_LAT-deep shift register of lin_slot_t with synchronous reset flush.

Test Plan:
- in=84, out=84, ACT_BITS=3, MEM_LAT=2, out_ready=1 -> 252 reads; act_bit sequence 2,1,0; 2 mac_shift pulses; out_valid at issue cycle 257; done 1 cycle after handshake.
- out=120 -> NT=2. Tile1 wgt_addr starts at 84. Holding out_ready low 5 cycles on tile0 keeps out_valid/out_tile=0 stable and stalls tile1 CLEAR; perf_stall=5 when LIN_SEQ_PERF_EN is defined.
- in=1, out=1 -> reads at ic=0 only; ACCUM/SHIFT alternate; 1+3+2+2=8 cycles to out_valid.
- in=0, then out=121 -> cfg_err pulse each time, busy stays 0, no reads issued.
- rst asserted during ACCUM of tile0 -> next cycle all outputs 0, no done; a new start runs cleanly from tile0.
- start pulsed while busy with different config -> ignored; original run completes unchanged.
